// File: rtl/truth_table_checker.sv
// Sweeps all 2^N_IN input vectors into a combinational DUT and compares each
// sampled output with a truth table that is latched on start.
module truth_table_checker #(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 3,
    parameter int SETTLE = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    input  logic                          i_abort,
    input  logic [N_OUT*(2**N_IN)-1:0]    i_exp_table,
    input  logic [N_OUT-1:0]              i_dut_out,
    output logic [N_IN-1:0]               o_vec,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_pass,
    output logic                          o_mismatch,
    output logic [N_IN:0]                 o_err_count,
    output logic [N_IN-1:0]               o_first_fail_idx,
    output logic                          o_first_fail_valid
);
    localparam int NV = 2**N_IN;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    // With no settle time every vector goes straight to its sample cycle.
    localparam state_t ST_FIRST = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

    state_t            r_state;
    logic [N_OUT-1:0]  r_exp [NV];
    logic [N_IN-1:0]   r_vec;
    logic [CW-1:0]     r_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic              r_mismatch;
    logic [N_IN:0]     r_err;
    logic [N_IN-1:0]   r_ffi;
    logic              r_ffv;

    logic              w_miss;
    logic              w_last;
    logic [N_IN:0]     w_err_next;

    assign w_miss     = (i_dut_out != r_exp[r_vec]);
    assign w_last     = (r_vec == N_IN'(NV - 1));
    assign w_err_next = r_err + {{N_IN{1'b0}}, w_miss};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_vec      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_mismatch <= 1'b0;
            r_err      <= '0;
            r_ffi      <= '0;
            r_ffv      <= 1'b0;
            for (int i = 0; i < NV; i++) r_exp[i] <= '0;
        end else begin
            r_mismatch <= 1'b0;
            if (i_abort) begin
                r_state <= S_IDLE;
                r_vec   <= '0;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
                r_pass  <= 1'b0;
                r_err   <= '0;
                r_ffi   <= '0;
                r_ffv   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (i_start) begin
                            r_state <= ST_FIRST;
                            r_vec   <= '0;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_pass  <= 1'b0;
                            r_err   <= '0;
                            r_ffi   <= '0;
                            r_ffv   <= 1'b0;
                            for (int i = 0; i < NV; i++)
                                r_exp[i] <= i_exp_table[i*N_OUT +: N_OUT];
                        end
                    end
                    S_SETTLE: begin
                        if (r_cnt == CW'(SETTLE - 1)) begin
                            r_cnt   <= '0;
                            r_state <= S_SAMPLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_SAMPLE: begin
                        r_err <= w_err_next;
                        if (w_miss) begin
                            r_mismatch <= 1'b1;
                            if (!r_ffv) begin
                                r_ffi <= r_vec;
                                r_ffv <= 1'b1;
                            end
                        end
                        // pass must reflect the compare made on this very edge.
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == '0);
                        end else begin
                            r_vec   <= r_vec + 1'b1;
                            r_state <= ST_FIRST;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_vec              = r_vec;
    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_pass             = r_pass;
    assign o_mismatch         = r_mismatch;
    assign o_err_count        = r_err;
    assign o_first_fail_idx   = r_ffi;
    assign o_first_fail_valid = r_ffv;
endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: default build (SETTLE=1) plus a SETTLE=0 build.
module tb_truth_table_checker;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    // SETTLE=1 instance
    logic        start = 1'b0, abort = 1'b0;
    logic [23:0] exp_table = '0;
    logic [2:0]  fault_a [8];
    logic [2:0]  dut_out, vec, ffi;
    logic        busy, done, pass, mism, ffv;
    logic [3:0]  errc;
    assign dut_out = vec ^ fault_a[vec];

    truth_table_checker #(.N_IN(3), .N_OUT(3), .SETTLE(1)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_exp_table(exp_table), .i_dut_out(dut_out), .o_vec(vec),
        .o_busy(busy), .o_done(done), .o_pass(pass), .o_mismatch(mism),
        .o_err_count(errc), .o_first_fail_idx(ffi), .o_first_fail_valid(ffv));

    // SETTLE=0 instance
    logic        start0 = 1'b0;
    logic        abort0 = 1'b0;
    logic [23:0] exp0 = '0;
    logic [2:0]  f0_at = '0, f0_mask = '0;
    logic [2:0]  dut_out0, vec0, ffi0;
    logic        busy0, done0, pass0, mism0, ffv0;
    logic [3:0]  errc0;
    assign dut_out0 = vec0 ^ ((vec0 == f0_at) ? f0_mask : 3'b000);

    truth_table_checker #(.N_IN(3), .N_OUT(3), .SETTLE(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start0), .i_abort(abort0),
        .i_exp_table(exp0), .i_dut_out(dut_out0), .o_vec(vec0),
        .o_busy(busy0), .o_done(done0), .o_pass(pass0), .o_mismatch(mism0),
        .o_err_count(errc0), .o_first_fail_idx(ffi0), .o_first_fail_valid(ffv0));

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] loop_tab();
        logic [23:0] r;
        for (int i = 0; i < 8; i++) r[i*3 +: 3] = 3'(i);
        return r;
    endfunction

    // The DUT answers i ^ fault[i]; a vector fails when that differs from the table.
    function automatic bit miss_at(input logic [23:0] e, input logic [23:0] f, input int i);
        logic [2:0] v;
        v = 3'(i);
        return (v ^ f[i*3 +: 3]) != e[i*3 +: 3];
    endfunction

    function automatic void model(input logic [23:0] e, input logic [23:0] f,
                                  output int err, output int idx, output bit fv, output bit ps);
        int fails_q[$];
        for (int i = 0; i < 8; i++) if (miss_at(e, f, i)) fails_q.push_back(i);
        err = fails_q.size();
        fv  = (err != 0);
        idx = fv ? fails_q[0] : 0;
        ps  = (err == 0);
    endfunction

    task automatic load_faults(input logic [23:0] f);
        for (int i = 0; i < 8; i++) fault_a[i] = f[i*3 +: 3];
    endtask

    task automatic run_sweep(input logic [23:0] e, input logic [23:0] f, input bit repulse,
                             input int x_err, input int x_idx, input bit x_ffv, input bit x_pass);
        int xv;
        exp_table = e;
        load_faults(f);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_done", done, 0);
        check("start_pass", pass, 0);
        check("start_vec", vec, 0);
        check("start_err", errc, 0);
        check("start_ffv", ffv, 0);
        // Edge c (relative to start) samples vector c/2-1 when c is even.
        for (int c = 1; c <= 16; c++) begin
            start = repulse && (c == 3 || c == 9);
            tick();
            start = 1'b0;
            xv = (c / 2 > 7) ? 7 : c / 2;
            check("sweep_vec", vec, xv);
            check("sweep_done", done, (c == 16));
            check("sweep_busy", busy, (c != 16));
            check("sweep_mismatch", mism, (c % 2 == 0) ? miss_at(e, f, c / 2 - 1) : 1'b0);
        end
        check("final_err", errc, x_err);
        check("final_idx", ffi, x_idx);
        check("final_ffv", ffv, x_ffv);
        check("final_pass", pass, x_pass);
    endtask

    typedef struct {
        logic [23:0] e;
        logic [23:0] f;
        int          err;
        int          idx;
        bit          fv;
        bit          ps;
    } vec_t;
    vec_t tv[6];

    initial begin
        int   m_err, m_idx;
        bit   m_fv, m_ps;
        logic [23:0] e, f;

        tv[0] = '{loop_tab(), 24'h0, 0, 0, 1'b0, 1'b1};
        tv[1] = '{loop_tab(), (24'd1 << 15) | (24'd1 << 18), 2, 5, 1'b1, 1'b0};
        tv[2] = '{loop_tab(), 24'hFFFFFF, 8, 0, 1'b1, 1'b0};
        tv[3] = '{loop_tab(), 24'd4 << 21, 1, 7, 1'b1, 1'b0};
        tv[4] = '{loop_tab(), 24'd2, 1, 0, 1'b1, 1'b0};
        tv[5] = '{24'h0, 24'h0, 7, 1, 1'b1, 1'b0};
        load_faults(24'h0);

        #12;
        check("rst_busy", busy, 0);
        check("rst_vec", vec, 0);
        check("rst_done", done, 0);
        check("rst_ffv", ffv, 0);
        check("rst_err", errc, 0);
        #6 rst_n = 1'b1;
        tick();

        for (int t = 0; t < 6; t++)
            run_sweep(tv[t].e, tv[t].f, 1'b0, tv[t].err, tv[t].idx, tv[t].fv, tv[t].ps);

        // done/pass held, vec does not wrap
        run_sweep(loop_tab(), 24'h0, 1'b1, 0, 0, 1'b0, 1'b1);
        repeat (3) tick();
        check("hold_done", done, 1);
        check("hold_pass", pass, 1);
        check("hold_vec", vec, 7);

        // abort while vec==3, with one error already counted
        exp_table = loop_tab();
        load_faults(24'd1 << 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("pre_abort_vec", vec, 3);
        check("pre_abort_err", errc, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_vec", vec, 0);
        check("abort_err", errc, 0);
        check("abort_ffv", ffv, 0);
        repeat (2) tick();
        check("abort_idle", busy, 0);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort_over_start", busy, 0);
        run_sweep(loop_tab(), 24'h0, 1'b0, 0, 0, 1'b0, 1'b1);

        // async reset mid-sweep
        exp_table = loop_tab();
        load_faults(24'd1 << 6);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        check("pre_rst_vec", vec, 4);
        check("pre_rst_err", errc, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_vec", vec, 0);
        check("arst_err", errc, 0);
        check("arst_ffv", ffv, 0);
        check("arst_ffi", ffi, 0);
        #2 rst_n = 1'b1;
        repeat (2) tick();
        check("post_rst_busy", busy, 0);
        check("post_rst_done", done, 0);
        check("post_rst_vec", vec, 0);

        // randomized tables and faults against the model
        for (int r = 0; r < 20; r++) begin
            e = ($urandom_range(0, 1) == 0) ? loop_tab() : 24'($urandom);
            f = '0;
            for (int i = 0; i < 8; i++)
                if ($urandom_range(0, 3) == 0) f[i*3 +: 3] = 3'($urandom_range(1, 7));
            model(e, f, m_err, m_idx, m_fv, m_ps);
            run_sweep(e, f, 1'b0, m_err, m_idx, m_fv, m_ps);
        end

        // SETTLE=0 build
        exp0 = loop_tab();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("s0_busy", busy0, 1);
        for (int c = 1; c <= 8; c++) begin
            tick();
            check("s0_done", done0, (c == 8));
            check("s0_vec", vec0, (c > 7) ? 7 : c);
        end
        check("s0_pass", pass0, 1);
        check("s0_err", errc0, 0);
        f0_at = 3'd3;
        f0_mask = 3'd1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("s0_restart_done", done0, 0);
        check("s0_restart_pass", pass0, 0);
        check("s0_restart_err", errc0, 0);
        check("s0_restart_busy", busy0, 1);
        for (int c = 1; c <= 8; c++) begin
            tick();
            check("s0_mismatch", mism0, (c == 4));
        end
        check("s0_fail_done", done0, 1);
        check("s0_fail_err", errc0, 1);
        check("s0_fail_idx", ffi0, 3);
        check("s0_fail_pass", pass0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
